noc_sink_collector: RTL and testbench
=====================================

NOC_SINK_COLLECTOR -- requirements
Module: noc_sink_collector

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- DATA_WIDTH, 32, flit width.
- DIM, 4, mesh dimension; header field base.
- MODULE_ID, 6'b000_000, local PE identifier.
- FIFO_DEPTH, 4, received-packet buffer entries (power of 2, >=2).
- TS_WIDTH, 16, injection-timestamp width.

REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1, the single clock.
- reset, in, 1, asynchronous, active-high reset.
- PacketIn, in, DATA_WIDTH, packet from the router local port.
- ReqUpStr, in, 1, router request to deliver PacketIn.
- GntUpStr, out, 1, grant pulse to the router.
- UpStrFull, out, 1, collector buffer full.
- RdEn, in, 1, PE pops the buffer head.
- RdData, out, DATA_WIDTH, buffer head packet.
- RdValid, out, 1, buffer non-empty.
- PktCount, out, 32, packets accepted since reset.
- LatLast, out, TS_WIDTH, latency of the last accepted packet.
- LatMax, out, TS_WIDTH, maximum latency since reset.
- CycleCount, out, 32, free-running cycle counter.

Function
REQ-003 Packet fields SHALL be:
- SenderID = PacketIn[DIM*4-11:0].
- PacketID = PacketIn[DIM*4-1 -: 10].
- InjTS = PacketIn[DIM*4+TS_WIDTH-1 : DIM*4].
REQ-004 The receive FSM SHALL have two states: WAIT_REQ and GRANT.
REQ-005 In WAIT_REQ, when ReqUpStr=1 and the FIFO is not full (count < FIFO_DEPTH, sampled before any same-cycle pop), the block SHALL:
- write PacketIn into the FIFO;
- set GntUpStr=1 next cycle;
- move to GRANT.
REQ-006 In WAIT_REQ, when ReqUpStr=1 and the FIFO is full, the block SHALL hold GntUpStr=0, stay in WAIT_REQ and drop nothing.
REQ-007 In GRANT the block SHALL clear GntUpStr and return to WAIT_REQ regardless of ReqUpStr. GntUpStr is therefore a single-cycle pulse, and accepts occur at most every 2 cycles.
REQ-008 UpStrFull SHALL be registered and equal (next FIFO count == FIFO_DEPTH), including the effect of same-cycle pushes and pops.
REQ-009 RdValid SHALL be 1 when the FIFO count is non-zero, and RdData SHALL show the head entry (first-word fall-through).
REQ-010 RdEn with RdValid=1 SHALL pop one entry; RdEn with RdValid=0 SHALL be ignored without underflow.
REQ-011 A push and a pop in the same cycle SHALL leave the count unchanged; pointers SHALL wrap modulo FIFO_DEPTH.
REQ-012 CycleCount SHALL increment every cycle and wrap at 2^32.
REQ-013 On each accept, the block SHALL update the following on the next clock edge:
- PktCount += 1, wrapping at 2^32;
- LatLast = CycleCount[TS_WIDTH-1:0] - InjTS, modulo 2^TS_WIDTH;
- LatMax = max(LatMax, new LatLast).
REQ-014 On each accept, simulation builds SHALL append "time ; CycleCount ; SenderID ; MODULE_ID ; PacketID ; LatLast" to a log file opened at time 0.

Reset
REQ-015 Asserting reset at any time, including mid-handshake, SHALL immediately set:
- FSM = WAIT_REQ;
- GntUpStr = 0, UpStrFull = 0, RdValid = 0;
- FIFO pointers and count = 0;
- PktCount = 0, LatLast = 0, LatMax = 0, CycleCount = 0.
REQ-016 Buffered packets SHALL be discarded on reset, and the FIFO storage array SHALL NOT require a reset.
REQ-017 The first accept SHALL be possible in the first cycle after reset deasserts.

Structure
REQ-018 Package noc_pkg SHALL hold:
- the collector state encoding (WAIT_REQ, GRANT);
- the header field offset/width constants;
- the TS_WIDTH default.
REQ-019 The buffer SHALL be one sub-module, collector_fifo, a synchronous FWFT FIFO parameterised by DATA_WIDTH and FIFO_DEPTH that exposes its count.
REQ-020 The FSM, counters and latency logic SHALL live in noc_sink_collector.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- Single packet: with CycleCount=100, ReqUpStr=1 and InjTS=90 -> GntUpStr pulses 1 cycle; PktCount=1; LatLast=10; RdValid=1; RdData=PacketIn.
- Continuous ReqUpStr=1, RdEn=0, FIFO_DEPTH=4 -> exactly 4 grants, 2 cycles apart; UpStrFull=1 after the 4th; no further grants.
- Full FIFO, then RdEn=1 for one cycle -> count 3; UpStrFull falls; the next request is granted; data order is FIFO.
- Timestamp wrap: CycleCount[15:0]=0x0005, InjTS=0xFFFB -> LatLast=10.
- Latencies 10, 40, 20 -> LatMax=40 and LatLast=20.
- Reset pulse in the GRANT state with 2 entries buffered -> GntUpStr=0, RdValid=0, PktCount=0 immediately; the next request is accepted normally.

Source files
------------

// File: rtl/noc_pkg.sv
// Shared definitions for the NoC sink collector: FSM encoding, header layout, defaults.
package noc_pkg;

    typedef enum logic {
        WAIT_REQ = 1'b0,
        GRANT    = 1'b1
    } collector_state_e;

    // Header: SenderID in the low bits, PacketID just below the timestamp base.
    localparam int unsigned HDR_DIM_SCALE    = 4;
    localparam int unsigned PACKET_ID_W      = 10;
    localparam int unsigned TS_WIDTH_DEFAULT = 16;

    function automatic int unsigned hdr_base(input int unsigned dim);
        return dim * HDR_DIM_SCALE;
    endfunction

endpackage

// File: rtl/collector_fifo.sv
// Synchronous first-word fall-through FIFO; exposes current and next-cycle occupancy.
module collector_fifo #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                push_i,
    input  logic                                pop_i,
    input  logic [DATA_WIDTH-1:0]               wdata_i,
    output logic [DATA_WIDTH-1:0]               rdata_o,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]     count_o,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]     count_nxt_o
);

    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  do_push, do_pop;

    // Overflow and underflow are blocked here, so callers may assert push/pop freely.
    assign do_push = push_i && (count_q != CW'(FIFO_DEPTH));
    assign do_pop  = pop_i && (count_q != CW'(0));

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        count_d = count_q + CW'(do_push) - CW'(do_pop);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage holds no reset; stale entries are unreachable once the pointers clear.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    assign rdata_o     = mem_q[rd_ptr_q];
    assign count_o     = count_q;
    assign count_nxt_o = count_d;

endmodule

// File: rtl/noc_sink_collector.sv
// NoC sink: accepts router packets into a FIFO with a two-state grant handshake
// and tracks packet count and injection-to-accept latency statistics.
module noc_sink_collector
    import noc_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DIM        = 4,
    parameter logic [5:0]  MODULE_ID  = 6'b000_000,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned TS_WIDTH   = TS_WIDTH_DEFAULT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] PacketIn,
    input  logic                  ReqUpStr,
    output logic                  GntUpStr,
    output logic                  UpStrFull,
    input  logic                  RdEn,
    output logic [DATA_WIDTH-1:0] RdData,
    output logic                  RdValid,
    output logic [31:0]           PktCount,
    output logic [TS_WIDTH-1:0]   LatLast,
    output logic [TS_WIDTH-1:0]   LatMax,
    output logic [31:0]           CycleCount
);

    localparam int unsigned HDR_BASE = hdr_base(DIM);
    localparam int unsigned CW       = $clog2(FIFO_DEPTH + 1);

    collector_state_e      state_q, state_d;
    logic                  gnt_q, gnt_d;
    logic                  full_q;
    logic [31:0]           pkt_q, pkt_d;
    logic [TS_WIDTH-1:0]   lat_last_q, lat_last_d;
    logic [TS_WIDTH-1:0]   lat_max_q, lat_max_d;
    logic [31:0]           cycle_q;

    logic [CW-1:0]         fifo_count, fifo_count_nxt;
    logic [TS_WIDTH-1:0]   inj_ts;
    logic [TS_WIDTH-1:0]   lat_new;
    logic                  accept;

    assign inj_ts  = PacketIn[HDR_BASE +: TS_WIDTH];
    assign lat_new = cycle_q[TS_WIDTH-1:0] - inj_ts;

    // Fullness is judged on the pre-pop count, so a same-cycle pop never frees a slot early.
    assign accept = (state_q == WAIT_REQ) && ReqUpStr && (fifo_count < CW'(FIFO_DEPTH));

    collector_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .push_i      (accept),
        .pop_i       (RdEn),
        .wdata_i     (PacketIn),
        .rdata_o     (RdData),
        .count_o     (fifo_count),
        .count_nxt_o (fifo_count_nxt)
    );

    always_comb begin
        state_d    = state_q;
        gnt_d      = 1'b0;
        pkt_d      = pkt_q;
        lat_last_d = lat_last_q;
        lat_max_d  = lat_max_q;
        case (state_q)
            WAIT_REQ: begin
                if (accept) begin
                    state_d = GRANT;
                    gnt_d   = 1'b1;
                end
            end
            GRANT: begin
                state_d = WAIT_REQ;
            end
            default: begin
                state_d = WAIT_REQ;
            end
        endcase
        if (accept) begin
            pkt_d      = pkt_q + 32'(1);
            lat_last_d = lat_new;
            if (lat_new > lat_max_q) begin
                lat_max_d = lat_new;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= WAIT_REQ;
            gnt_q      <= 1'b0;
            full_q     <= 1'b0;
            pkt_q      <= '0;
            lat_last_q <= '0;
            lat_max_q  <= '0;
            cycle_q    <= '0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            full_q     <= (fifo_count_nxt == CW'(FIFO_DEPTH));
            pkt_q      <= pkt_d;
            lat_last_q <= lat_last_d;
            lat_max_q  <= lat_max_d;
            cycle_q    <= cycle_q + 32'(1);
        end
    end

    assign GntUpStr   = gnt_q;
    assign UpStrFull  = full_q;
    assign RdValid    = (fifo_count != CW'(0));
    assign PktCount   = pkt_q;
    assign LatLast    = lat_last_q;
    assign LatMax     = lat_max_q;
    assign CycleCount = cycle_q;

`ifndef SYNTHESIS
    // Per-accept trace: time ; CycleCount ; SenderID ; MODULE_ID ; PacketID ; LatLast
    logic [HDR_BASE-PACKET_ID_W-1:0] sender_id;
    logic [PACKET_ID_W-1:0]          packet_id;

    assign sender_id = PacketIn[HDR_BASE-PACKET_ID_W-1:0];
    assign packet_id = PacketIn[HDR_BASE-1 -: PACKET_ID_W];

    always_ff @(posedge clk) begin
        if (!reset && accept) begin
            $display("%0t ; %0d ; %0d ; %0d ; %0d ; %0d",
                     $time, cycle_q, sender_id, MODULE_ID, packet_id, lat_new);
        end
    end
`endif

endmodule

// File: tb/tb_noc_sink_collector.sv
// Directed bench for noc_sink_collector: table-driven fill/drain plus reset and latency sequences.
module tb_noc_sink_collector;

    logic        clk;
    logic        reset;
    logic [31:0] PacketIn;
    logic        ReqUpStr;
    logic        GntUpStr;
    logic        UpStrFull;
    logic        RdEn;
    logic [31:0] RdData;
    logic        RdValid;
    logic [31:0] PktCount;
    logic [15:0] LatLast;
    logic [15:0] LatMax;
    logic [31:0] CycleCount;

    noc_sink_collector #(
        .DATA_WIDTH (32),
        .DIM        (4),
        .MODULE_ID  (6'd5),
        .FIFO_DEPTH (4),
        .TS_WIDTH   (16)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .PacketIn   (PacketIn),
        .ReqUpStr   (ReqUpStr),
        .GntUpStr   (GntUpStr),
        .UpStrFull  (UpStrFull),
        .RdEn       (RdEn),
        .RdData     (RdData),
        .RdValid    (RdValid),
        .PktCount   (PktCount),
        .LatLast    (LatLast),
        .LatMax     (LatMax),
        .CycleCount (CycleCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference cycle counter: edges seen since reset released.
    int unsigned tb_cyc;
    always @(posedge clk or posedge reset) begin
        if (reset) tb_cyc <= 0;
        else       tb_cyc <= tb_cyc + 1;
    end

    int unsigned n_vec;
    int unsigned n_err;
    int unsigned mdl_pkt;
    logic [15:0] mdl_last;
    logic [15:0] mdl_max;

    typedef struct {
        logic        req;
        logic        rden;
        int unsigned lat;
        logic [9:0]  pid;
        logic        gnt;
        logic        full;
        logic        valid;
        logic [9:0]  head;
    } vec_t;

    vec_t tbl [22];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic logic [31:0] mk_pkt(input logic [15:0] ts, input logic [9:0] pid, input logic [5:0] sid);
        return {ts, pid, sid};
    endfunction

    function automatic logic [31:0] lat_pkt(input int unsigned lat, input logic [9:0] pid);
        return mk_pkt(16'(tb_cyc - lat), pid, 6'd2);
    endfunction

    task automatic chk_reset_state();
        chk("rst_gnt",   32'(GntUpStr),  32'd0);
        chk("rst_full",  32'(UpStrFull), 32'd0);
        chk("rst_valid", 32'(RdValid),   32'd0);
        chk("rst_pkt",   PktCount,       32'd0);
        chk("rst_last",  32'(LatLast),   32'd0);
        chk("rst_max",   32'(LatMax),    32'd0);
        chk("rst_cyc",   CycleCount,     32'd0);
    endtask

    // Drive one cycle of inputs, then check every output after the edge.
    task automatic step(input logic req, input logic rden, input logic [31:0] pkt,
                        input logic eg, input logic ef, input logic ev,
                        input logic [9:0] eh, input logic [15:0] el);
        ReqUpStr = req;
        RdEn     = rden;
        PacketIn = pkt;
        @(posedge clk);
        #1;
        if (eg) begin
            mdl_pkt++;
            mdl_last = el;
            if (el > mdl_max) mdl_max = el;
        end
        chk("gnt",      32'(GntUpStr),  32'(eg));
        chk("full",     32'(UpStrFull), 32'(ef));
        chk("rdvalid",  32'(RdValid),   32'(ev));
        if (ev) chk("head_pid", 32'(RdData[15:6]), 32'(eh));
        chk("pktcount", PktCount,       mdl_pkt);
        chk("lat_last", 32'(LatLast),   32'(mdl_last));
        chk("lat_max",  32'(LatMax),    32'(mdl_max));
        chk("cycle",    CycleCount,     tb_cyc);
    endtask

    task automatic idle_until(input int unsigned target);
        int unsigned guard;
        guard    = 0;
        ReqUpStr = 1'b0;
        RdEn     = 1'b0;
        while (tb_cyc < target && guard < 1000) begin
            @(posedge clk);
            #1;
            guard++;
        end
        chk("reach_cycle", tb_cyc, target);
    endtask

    task automatic do_reset();
        ReqUpStr = 1'b0;
        RdEn     = 1'b0;
        reset    = 1'b1;
        mdl_pkt  = 0;
        mdl_last = '0;
        mdl_max  = '0;
        @(posedge clk);
        #1;
        chk_reset_state();
        reset = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] pkt;
        n_vec    = 0;
        n_err    = 0;
        mdl_pkt  = 0;
        mdl_last = '0;
        mdl_max  = '0;
        reset    = 1'b1;
        ReqUpStr = 1'b0;
        RdEn     = 1'b0;
        PacketIn = '0;

        //            req  rden lat pid     gnt  full valid head
        tbl[0]  = '{1'b1, 1'b0, 5, 10'h011, 1'b1, 1'b0, 1'b1, 10'h011};
        tbl[1]  = '{1'b1, 1'b0, 5, 10'h012, 1'b0, 1'b0, 1'b1, 10'h011};
        tbl[2]  = '{1'b1, 1'b0, 6, 10'h012, 1'b1, 1'b0, 1'b1, 10'h011};
        tbl[3]  = '{1'b1, 1'b0, 6, 10'h013, 1'b0, 1'b0, 1'b1, 10'h011};
        tbl[4]  = '{1'b1, 1'b0, 7, 10'h013, 1'b1, 1'b0, 1'b1, 10'h011};
        tbl[5]  = '{1'b1, 1'b0, 7, 10'h014, 1'b0, 1'b0, 1'b1, 10'h011};
        tbl[6]  = '{1'b1, 1'b0, 8, 10'h014, 1'b1, 1'b1, 1'b1, 10'h011};
        tbl[7]  = '{1'b1, 1'b0, 8, 10'h015, 1'b0, 1'b1, 1'b1, 10'h011};
        tbl[8]  = '{1'b1, 1'b0, 8, 10'h015, 1'b0, 1'b1, 1'b1, 10'h011};
        tbl[9]  = '{1'b1, 1'b0, 8, 10'h015, 1'b0, 1'b1, 1'b1, 10'h011};
        tbl[10] = '{1'b1, 1'b1, 9, 10'h015, 1'b0, 1'b0, 1'b1, 10'h012};
        tbl[11] = '{1'b1, 1'b0, 9, 10'h015, 1'b1, 1'b1, 1'b1, 10'h012};
        tbl[12] = '{1'b0, 1'b0, 0, 10'h000, 1'b0, 1'b1, 1'b1, 10'h012};
        tbl[13] = '{1'b0, 1'b1, 0, 10'h000, 1'b0, 1'b0, 1'b1, 10'h013};
        tbl[14] = '{1'b0, 1'b1, 0, 10'h000, 1'b0, 1'b0, 1'b1, 10'h014};
        tbl[15] = '{1'b0, 1'b1, 0, 10'h000, 1'b0, 1'b0, 1'b1, 10'h015};
        tbl[16] = '{1'b0, 1'b1, 0, 10'h000, 1'b0, 1'b0, 1'b0, 10'h000};
        tbl[17] = '{1'b0, 1'b1, 0, 10'h000, 1'b0, 1'b0, 1'b0, 10'h000};
        tbl[18] = '{1'b1, 1'b0, 3, 10'h021, 1'b1, 1'b0, 1'b1, 10'h021};
        tbl[19] = '{1'b0, 1'b0, 0, 10'h000, 1'b0, 1'b0, 1'b1, 10'h021};
        tbl[20] = '{1'b1, 1'b1, 4, 10'h022, 1'b1, 1'b0, 1'b1, 10'h022};
        tbl[21] = '{1'b0, 1'b1, 0, 10'h000, 1'b0, 1'b0, 1'b0, 10'h000};

        // Power-on reset state.
        repeat (3) @(posedge clk);
        #1;
        chk_reset_state();
        reset = 1'b0;

        // Single packet accepted at CycleCount=100 with InjTS=90.
        idle_until(100);
        pkt = mk_pkt(16'd90, 10'h001, 6'd3);
        step(1'b1, 1'b0, pkt, 1'b1, 1'b0, 1'b1, 10'h001, 16'd10);
        chk("single_rddata", RdData, pkt);
        chk("single_latlast", 32'(LatLast), 32'd10);
        step(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1, 10'h001, 16'd0);
        step(1'b0, 1'b1, '0, 1'b0, 1'b0, 1'b0, 10'h000, 16'd0);
        step(1'b0, 1'b1, '0, 1'b0, 1'b0, 1'b0, 10'h000, 16'd0);

        // Fill to full, single pop, refill, drain, then same-cycle push and pop.
        for (int i = 0; i < 22; i++) begin
            step(tbl[i].req, tbl[i].rden, lat_pkt(tbl[i].lat, tbl[i].pid),
                 tbl[i].gnt, tbl[i].full, tbl[i].valid, tbl[i].head, 16'(tbl[i].lat));
        end

        // Two entries buffered, FSM in GRANT, then reset mid-cycle.
        step(1'b1, 1'b0, lat_pkt(2, 10'h031), 1'b1, 1'b0, 1'b1, 10'h031, 16'd2);
        step(1'b1, 1'b0, lat_pkt(2, 10'h032), 1'b0, 1'b0, 1'b1, 10'h031, 16'd0);
        step(1'b1, 1'b0, lat_pkt(2, 10'h032), 1'b1, 1'b0, 1'b1, 10'h031, 16'd2);
        ReqUpStr = 1'b0;
        reset    = 1'b1;
        mdl_pkt  = 0;
        mdl_last = '0;
        mdl_max  = '0;
        #1;
        chk_reset_state();
        #1;
        reset = 1'b0;

        // First cycle after reset accepts; latencies 10, 40, 20.
        step(1'b1, 1'b0, lat_pkt(10, 10'h041), 1'b1, 1'b0, 1'b1, 10'h041, 16'd10);
        step(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1, 10'h041, 16'd0);
        step(1'b1, 1'b0, lat_pkt(40, 10'h042), 1'b1, 1'b0, 1'b1, 10'h041, 16'd40);
        step(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1, 10'h041, 16'd0);
        step(1'b1, 1'b0, lat_pkt(20, 10'h043), 1'b1, 1'b0, 1'b1, 10'h041, 16'd20);
        chk("scn_latmax",  32'(LatMax),  32'd40);
        chk("scn_latlast", 32'(LatLast), 32'd20);
        chk("scn_pkt",     PktCount,     32'd3);

        // Timestamp wrap: CycleCount low bits 0x0005, InjTS 0xFFFB.
        do_reset();
        idle_until(5);
        step(1'b1, 1'b0, mk_pkt(16'hFFFB, 10'h051, 6'd7), 1'b1, 1'b0, 1'b1, 10'h051, 16'd10);
        chk("wrap_latlast", 32'(LatLast), 32'd10);
        ReqUpStr = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
